// File: rtl/mdu_e.sv
// EX-stage multiply/divide unit with HI/LO registers and a fixed-latency busy counter.
// Results are computed at issue, held in res_hi/res_lo, and committed when the counter expires.
module mdu_e #(
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ir_e,
   input  logic [31:0] ir_d,
   input  logic [31:0] rs_e,
   input  logic [31:0] rt_e,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdout
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = ($clog2(MAX_LAT + 1) > 4) ? $clog2(MAX_LAT + 1) : 4;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic is_mdu_op(input logic [31:0] ir);
      logic r;
      r = 1'b0;
      if (ir[31:26] == 6'b000000) begin
         case (ir[5:0])
            F_MFHI, F_MTHI, F_MFLO, F_MTLO,
            F_MULT, F_MULTU, F_DIV, F_DIVU: r = 1'b1;
            default:                        r = 1'b0;
         endcase
      end else begin
         r = 1'b0;
      end
      return r;
   endfunction

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [31:0]      res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic             res_wr_q, res_wr_d;

   logic        r_type_s;
   logic [5:0]  funct_s;
   logic        is_mul_s, is_div_s, start_s;
   logic [63:0] prod_s_s, prod_u_s;
   logic [31:0] divisor_s, dividend_s, quo_s_s, rem_s_s, quo_u_s, rem_u_s;
   logic        div_ovf_s;
   logic signed [31:0] sa_s, sb_s;
   logic        unused_s;

   assign r_type_s = (ir_e[31:26] == 6'b000000);
   assign funct_s  = ir_e[5:0];
   assign is_mul_s = r_type_s && ((funct_s == F_MULT) || (funct_s == F_MULTU));
   assign is_div_s = r_type_s && ((funct_s == F_DIV)  || (funct_s == F_DIVU));
   assign busy     = (cnt_q != CNT_ZERO);
   assign start_s  = (is_mul_s || is_div_s) && !busy;
   assign unused_s = ^{ir_e[25:6], ir_d[25:6]};

   // Arithmetic datapath; zero divisor and MIN/-1 are steered away from the divider
   always_comb begin
      prod_s_s   = $signed({{32{rs_e[31]}}, rs_e}) * $signed({{32{rt_e[31]}}, rt_e});
      prod_u_s   = {32'h0000_0000, rs_e} * {32'h0000_0000, rt_e};
      div_ovf_s  = (rs_e == 32'h8000_0000) && (rt_e == 32'hFFFF_FFFF);
      divisor_s  = (rt_e == 32'h0000_0000) ? 32'h0000_0001 : rt_e;
      dividend_s = div_ovf_s ? 32'h0000_0000 : rs_e;
      sa_s       = $signed(dividend_s);
      sb_s       = $signed(divisor_s);
      quo_s_s    = div_ovf_s ? 32'h8000_0000 : 32'(sa_s / sb_s);
      rem_s_s    = div_ovf_s ? 32'h0000_0000 : 32'(sa_s % sb_s);
      quo_u_s    = rs_e / divisor_s;
      rem_u_s    = rs_e % divisor_s;
   end

   // Next-state: issue, countdown/commit, and zero-latency moves to HI/LO
   always_comb begin
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      res_wr_d = res_wr_q;
      if (start_s) begin
         case (funct_s)
            F_MULT:  begin res_hi_d = prod_s_s[63:32]; res_lo_d = prod_s_s[31:0]; end
            F_MULTU: begin res_hi_d = prod_u_s[63:32]; res_lo_d = prod_u_s[31:0]; end
            F_DIV:   begin res_hi_d = rem_s_s;         res_lo_d = quo_s_s;        end
            F_DIVU:  begin res_hi_d = rem_u_s;         res_lo_d = quo_u_s;        end
            default: begin res_hi_d = res_hi_q;        res_lo_d = res_lo_q;       end
         endcase
         res_wr_d = is_mul_s || (rt_e != 32'h0000_0000);
         cnt_d    = is_mul_s ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
      end else if (busy) begin
         if (cnt_q == CNT_ONE) begin
            cnt_d = CNT_ZERO;
            if (res_wr_q) begin
               hi_d = res_hi_q;
               lo_d = res_lo_q;
            end else begin
               hi_d = hi_q;
               lo_d = lo_q;
            end
         end else begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end else if (r_type_s && (funct_s == F_MTHI)) begin
         hi_d = rs_e;
      end else if (r_type_s && (funct_s == F_MTLO)) begin
         lo_d = rs_e;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q    <= CNT_ZERO;
         hi_q     <= 32'h0000_0000;
         lo_q     <= 32'h0000_0000;
         res_hi_q <= 32'h0000_0000;
         res_lo_q <= 32'h0000_0000;
         res_wr_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         res_wr_q <= res_wr_d;
      end
   end

   assign hi        = hi_q;
   assign lo        = lo_q;
   assign stall_req = (busy || start_s) && is_mdu_op(ir_d);
   assign mdout     = (r_type_s && (funct_s == F_MFHI)) ? hi_q :
                      (r_type_s && (funct_s == F_MFLO)) ? lo_q : 32'h0000_0000;

endmodule
